pingpong_ram_ctrl: RTL and testbench

PINGPONG_RAM_CTRL -- requirements
Module: pingpong_ram_ctrl

---
 rtl/pingpong_ram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pingpong_ram_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_ram_ctrl.sv
// pingpong_ram_ctrl: two-bank ping-pong frame buffer with dual-lane write and read.
// The writer fills bank wsel while the reader drains bank rsel; per-bank full flags
// hand banks over on the frame-done pulses.
// Optional build macro: PINGPONG_RD_REG_EN adds an output register stage, so reads
// take 2 cycles instead of 1.
module pingpong_ram_ctrl #(
  parameter int unsigned width     = 64,
  parameter int unsigned size      = 1024,
  parameter int unsigned addr_size = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en_a,
  input  logic                 wr_en_b,
  input  logic [addr_size-1:0] addr_write_a,
  input  logic [addr_size-1:0] addr_write_b,
  input  logic [width-1:0]     data_a_in,
  input  logic [width-1:0]     data_b_in,
  input  logic                 wr_frame_done,
  input  logic                 rd_en_a,
  input  logic                 rd_en_b,
  input  logic [addr_size-1:0] addr_read_a,
  input  logic [addr_size-1:0] addr_read_b,
  input  logic                 rd_frame_done,
  output logic [width-1:0]     data_a_out,
  output logic [width-1:0]     data_b_out,
  output logic                 rd_valid_a,
  output logic                 rd_valid_b,
  output logic                 wr_ready,
  output logic                 rd_ready,
  output logic                 ram_select,
  output logic [1:0]           frames,
  output logic                 err_wr,
  output logic                 err_rd
);

  // One extra bit so that size itself (e.g. 1024 with 10 address bits) is representable.
  localparam int unsigned AW1 = addr_size + 1;
  localparam logic [AW1-1:0] SIZE_L = AW1'(size);

  // Bank storage; never reset.
  logic [width-1:0] mem_q [2][size];

  // Bank handover state.
  logic [1:0] full_q, full_d;
  logic       wsel_q, wsel_d;
  logic       rsel_q, rsel_d;
  logic       err_wr_q, err_wr_d;
  logic       err_rd_q, err_rd_d;

  // First read stage.
  logic             rd_valid_a_q, rd_valid_b_q;
  logic [width-1:0] rd_data_a_q, rd_data_b_q;

  // Qualified requests.
  logic wr_in_range_a, wr_in_range_b;
  logic rd_in_range_a, rd_in_range_b;
  logic wr_fire_a, wr_fire_b, wr_done_fire;
  logic rd_fire_a, rd_fire_b, rd_done_fire;
  logic wr_viol, rd_viol;

  // Status derived directly from the handover state.
  assign wr_ready   = !full_q[wsel_q];
  assign rd_ready   = full_q[rsel_q];
  assign frames     = 2'(full_q[0]) + 2'(full_q[1]);
  assign ram_select = wsel_q;
  assign err_wr     = err_wr_q;
  assign err_rd     = err_rd_q;

  // Out-of-range addresses are silently ignored; they never raise an error.
  assign wr_in_range_a = ({1'b0, addr_write_a} < SIZE_L);
  assign wr_in_range_b = ({1'b0, addr_write_b} < SIZE_L);
  assign rd_in_range_a = ({1'b0, addr_read_a} < SIZE_L);
  assign rd_in_range_b = ({1'b0, addr_read_b} < SIZE_L);

  // Requests only take effect while the owning side holds a usable bank.
  assign wr_fire_a    = wr_en_a && wr_ready && wr_in_range_a;
  assign wr_fire_b    = wr_en_b && wr_ready && wr_in_range_b;
  assign wr_done_fire = wr_frame_done && wr_ready;
  assign rd_fire_a    = rd_en_a && rd_ready && rd_in_range_a;
  assign rd_fire_b    = rd_en_b && rd_ready && rd_in_range_b;
  assign rd_done_fire = rd_frame_done && rd_ready;

  // Any request presented to a side that has no usable bank is a protocol violation.
  assign wr_viol = !wr_ready && (wr_en_a || wr_en_b || wr_frame_done);
  assign rd_viol = !rd_ready && (rd_en_a || rd_en_b || rd_frame_done);

  // Next-state for bank ownership and sticky error flags.
  always_comb begin
    full_d   = full_q;
    wsel_d   = wsel_q;
    rsel_d   = rsel_q;
    err_wr_d = err_wr_q;
    err_rd_d = err_rd_q;
    // Writer and reader always own different banks, so both updates can apply together.
    if (wr_done_fire) begin
      full_d[wsel_q] = 1'b1;
      wsel_d         = ~wsel_q;
    end
    if (rd_done_fire) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end
    if (wr_viol) begin
      err_wr_d = 1'b1;
    end
    if (rd_viol) begin
      err_rd_d = 1'b1;
    end
  end

  // Handover state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 2'b00;
      wsel_q   <= 1'b0;
      rsel_q   <= 1'b0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wsel_q   <= wsel_d;
      rsel_q   <= rsel_d;
      err_wr_q <= err_wr_d;
      err_rd_q <= err_rd_d;
    end
  end

  // Bank write; lane b is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_fire_a) begin
        mem_q[wsel_q][addr_write_a] <= data_a_in;
      end
      if (wr_fire_b) begin
        mem_q[wsel_q][addr_write_b] <= data_b_in;
      end
    end
  end

  // First read stage: data updates only on a qualified read and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_a_q <= 1'b0;
      rd_valid_b_q <= 1'b0;
      rd_data_a_q  <= '0;
      rd_data_b_q  <= '0;
    end else begin
      rd_valid_a_q <= rd_fire_a;
      rd_valid_b_q <= rd_fire_b;
      if (rd_fire_a) begin
        rd_data_a_q <= mem_q[rsel_q][addr_read_a];
      end
      if (rd_fire_b) begin
        rd_data_b_q <= mem_q[rsel_q][addr_read_b];
      end
    end
  end

`ifdef PINGPONG_RD_REG_EN
  // Second read stage.
  logic             rd_valid_a_q2, rd_valid_b_q2;
  logic [width-1:0] rd_data_a_q2, rd_data_b_q2;

  // Output register stage; data follows stage one only when it carries a valid word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_a_q2 <= 1'b0;
      rd_valid_b_q2 <= 1'b0;
      rd_data_a_q2  <= '0;
      rd_data_b_q2  <= '0;
    end else begin
      rd_valid_a_q2 <= rd_valid_a_q;
      rd_valid_b_q2 <= rd_valid_b_q;
      if (rd_valid_a_q) begin
        rd_data_a_q2 <= rd_data_a_q;
      end
      if (rd_valid_b_q) begin
        rd_data_b_q2 <= rd_data_b_q;
      end
    end
  end

  assign data_a_out = rd_data_a_q2;
  assign data_b_out = rd_data_b_q2;
  assign rd_valid_a = rd_valid_a_q2;
  assign rd_valid_b = rd_valid_b_q2;
`else
  assign data_a_out = rd_data_a_q;
  assign data_b_out = rd_data_b_q;
  assign rd_valid_a = rd_valid_a_q;
  assign rd_valid_b = rd_valid_b_q;
`endif

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Directed bench for pingpong_ram_ctrl; follows PINGPONG_RD_REG_EN for read latency.
module tb_pingpong_ram_ctrl;

`ifdef PINGPONG_RD_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en_a, wr_en_b;
  logic [9:0]  addr_write_a, addr_write_b;
  logic [63:0] data_a_in, data_b_in;
  logic        wr_frame_done;
  logic        rd_en_a, rd_en_b;
  logic [9:0]  addr_read_a, addr_read_b;
  logic        rd_frame_done;
  logic [63:0] data_a_out, data_b_out;
  logic        rd_valid_a, rd_valid_b;
  logic        wr_ready, rd_ready;
  logic        ram_select;
  logic [1:0]  frames;
  logic        err_wr, err_rd;

  int checks = 0;
  int errors = 0;

  pingpong_ram_ctrl #(.width(64), .size(1024), .addr_size(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en_a       (wr_en_a),
    .wr_en_b       (wr_en_b),
    .addr_write_a  (addr_write_a),
    .addr_write_b  (addr_write_b),
    .data_a_in     (data_a_in),
    .data_b_in     (data_b_in),
    .wr_frame_done (wr_frame_done),
    .rd_en_a       (rd_en_a),
    .rd_en_b       (rd_en_b),
    .addr_read_a   (addr_read_a),
    .addr_read_b   (addr_read_b),
    .rd_frame_done (rd_frame_done),
    .data_a_out    (data_a_out),
    .data_b_out    (data_b_out),
    .rd_valid_a    (rd_valid_a),
    .rd_valid_b    (rd_valid_b),
    .wr_ready      (wr_ready),
    .rd_ready      (rd_ready),
    .ram_select    (ram_select),
    .frames        (frames),
    .err_wr        (err_wr),
    .err_rd        (err_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_a = 1'b0; wr_en_b = 1'b0;
    addr_write_a = '0; addr_write_b = '0;
    data_a_in = '0; data_b_in = '0;
    wr_frame_done = 1'b0;
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    addr_read_a = '0; addr_read_b = '0;
    rd_frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wr2(input logic ea, input logic [9:0] aa, input logic [63:0] da,
                     input logic eb, input logic [9:0] ab, input logic [63:0] db);
    wr_en_a = ea; addr_write_a = aa; data_a_in = da;
    wr_en_b = eb; addr_write_b = ab; data_b_in = db;
    tick();
    idle();
  endtask

  task automatic pulse_wr_done();
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
  endtask

  task automatic pulse_rd_done();
    rd_frame_done = 1'b1;
    tick();
    rd_frame_done = 1'b0;
  endtask

  // Issue a read on both lanes, check data after LAT cycles, then check valid drops and data holds.
  task automatic read2(input string tag, input logic [9:0] aa, input logic [9:0] ab,
                       input logic [63:0] ea, input logic [63:0] eb);
    rd_en_a = 1'b1; addr_read_a = aa;
    rd_en_b = 1'b1; addr_read_b = ab;
    tick();
    idle();
    repeat (LAT - 1) tick();
    chk({tag, "_valid_a"}, 64'(rd_valid_a), 64'(1));
    chk({tag, "_valid_b"}, 64'(rd_valid_b), 64'(1));
    chk({tag, "_data_a"}, data_a_out, ea);
    chk({tag, "_data_b"}, data_b_out, eb);
    tick();
    chk({tag, "_valid_a_drop"}, 64'(rd_valid_a), 64'(0));
    chk({tag, "_hold_a"}, data_a_out, ea);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_rd_ready", 64'(rd_ready), 64'(0));
    chk("rst_frames", 64'(frames), 64'(0));
    chk("rst_ram_select", 64'(ram_select), 64'(0));
    chk("rst_err_wr", 64'(err_wr), 64'(0));
    chk("rst_err_rd", 64'(err_rd), 64'(0));
    chk("rst_valid_a", 64'(rd_valid_a), 64'(0));
    chk("rst_data_a", data_a_out, 64'(0));

    // Early read with no full bank
    rd_en_a = 1'b1; addr_read_a = 10'd0;
    tick();
    idle();
    chk("early_err_rd", 64'(err_rd), 64'(1));
    chk("early_valid_1", 64'(rd_valid_a), 64'(0));
    tick();
    chk("early_valid_2", 64'(rd_valid_a), 64'(0));
    chk("early_frames", 64'(frames), 64'(0));
    do_reset();
    chk("early_err_cleared", 64'(err_rd), 64'(0));

    // Basic frame into bank 0
    wr2(1'b1, 10'd3, 64'h11, 1'b1, 10'd4, 64'h22);
    pulse_wr_done();
    chk("basic_ram_select", 64'(ram_select), 64'(1));
    chk("basic_rd_ready", 64'(rd_ready), 64'(1));
    chk("basic_frames", 64'(frames), 64'(1));
    chk("basic_wr_ready", 64'(wr_ready), 64'(1));
    read2("basic", 10'd3, 10'd4, 64'h11, 64'h22);

    // Same-address collision into bank 1, then simultaneous frame-done
    wr2(1'b1, 10'd7, 64'hA, 1'b1, 10'd7, 64'hB);
    wr_frame_done = 1'b1;
    rd_frame_done = 1'b1;
    tick();
    idle();
    chk("simul_frames", 64'(frames), 64'(1));
    chk("simul_ram_select", 64'(ram_select), 64'(0));
    chk("simul_rd_ready", 64'(rd_ready), 64'(1));
    chk("simul_wr_ready", 64'(wr_ready), 64'(1));
    read2("collide", 10'd7, 10'd7, 64'hB, 64'hB);

    // Double full: fill bank 0 while bank 1 still unread
    wr2(1'b1, 10'd0, 64'h33, 1'b0, 10'd0, 64'h0);
    pulse_wr_done();
    chk("dfull_frames", 64'(frames), 64'(2));
    chk("dfull_wr_ready", 64'(wr_ready), 64'(0));
    chk("dfull_ram_select", 64'(ram_select), 64'(1));
    chk("dfull_err_wr_pre", 64'(err_wr), 64'(0));
    wr2(1'b1, 10'd0, 64'hFF, 1'b1, 10'd7, 64'hFF);
    chk("dfull_err_wr", 64'(err_wr), 64'(1));
    pulse_wr_done();
    chk("dfull_frames_kept", 64'(frames), 64'(2));
    chk("dfull_sel_kept", 64'(ram_select), 64'(1));
    read2("dfull_b1", 10'd7, 10'd7, 64'hB, 64'hB);
    pulse_rd_done();
    chk("drain_frames", 64'(frames), 64'(1));
    chk("drain_rd_ready", 64'(rd_ready), 64'(1));
    read2("dfull_b0", 10'd0, 10'd0, 64'h33, 64'h33);
    chk("err_rd_still_0", 64'(err_rd), 64'(0));

    // Mid-operation reset with both banks full
    wr2(1'b1, 10'd5, 64'h55, 1'b0, 10'd0, 64'h0);
    pulse_wr_done();
    chk("mid_frames", 64'(frames), 64'(2));
    wr2(1'b1, 10'd1, 64'h77, 1'b0, 10'd0, 64'h0);
    chk("mid_err_wr", 64'(err_wr), 64'(1));
    rst = 1'b1;
    wr_en_a = 1'b1; addr_write_a = 10'd2; data_a_in = 64'h99;
    wr_frame_done = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("mid_rst_frames", 64'(frames), 64'(0));
    chk("mid_rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("mid_rst_rd_ready", 64'(rd_ready), 64'(0));
    chk("mid_rst_err_wr", 64'(err_wr), 64'(0));
    chk("mid_rst_err_rd", 64'(err_rd), 64'(0));
    chk("mid_rst_ram_select", 64'(ram_select), 64'(0));
    chk("mid_rst_data_a", data_a_out, 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
